// File: rtl/stopwatch_ctrl.sv
// Push-button front end for the stopwatch: synchronise, debounce, prioritise the
// three buttons and sequence start/clear pulses plus a timed lap-hold display.
//
// state  | meaning
// IDLE   | stopped at zero; start runs, clear re-issues a clear
// RUN    | counting; start pauses, lap captures the current time
// LAP    | counting with the captured lap shown until the hold timer expires
// PAUSE  | stopped with time kept; start resumes, clear zeroes everything
module stopwatch_ctrl #(
  parameter int FREQ_HZ     = 100000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LAP_HOLD_MS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  input  logic [31:0] time_display,
  output logic        start_pulse,
  output logic        clear_pulse,
  output logic        running,
  output logic        lap_active,
  output logic [3:0]  lap_count,
  output logic [31:0] display_value
);

  localparam int DEBOUNCE_CYCLES = FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LAP_HOLD_CYCLES = FREQ_HZ / 1000 * LAP_HOLD_MS;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LAP_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LAP_HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  // Bit order everywhere: {lap, clear, start}
  logic [2:0]        btn_raw;
  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic [2:0]        stable;
  logic [2:0]        evt;
  logic [DB_W-1:0]   db_cnt [3];
  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       lap_reg;
  logic              ev_start;
  logic              ev_clear;
  logic              ev_lap;

  assign btn_raw = {btn_lap, btn_clear, btn_start};

  // Event fires in the same edge the stable state rises, keeping latency at D+3.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      evt    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      evt   <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stable[i] <= sync2[i];
          evt[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Priority start > clear > lap; a lower event is dropped even if the state ignores the winner.
  assign ev_start = evt[0];
  assign ev_clear = evt[1] & ~evt[0];
  assign ev_lap   = evt[2] & ~evt[1] & ~evt[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      lap_count   <= 4'd0;
      lap_reg     <= 32'd0;
      hold_cnt    <= '0;
    end else begin
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ev_start) begin
            start_pulse <= 1'b1;
            state       <= S_RUN;
          end else if (ev_clear) begin
            clear_pulse <= 1'b1;
          end
        end
        S_RUN: begin
          if (ev_start) begin
            start_pulse <= 1'b1;
            state       <= S_PAUSE;
          end else if (ev_lap) begin
            lap_reg   <= time_display;
            lap_count <= (lap_count == 4'd15) ? lap_count : lap_count + 4'd1;
            hold_cnt  <= HOLD_LOAD;
            state     <= S_LAP;
          end
        end
        S_LAP: begin
          if (ev_start) begin
            start_pulse <= 1'b1;
            state       <= S_PAUSE;
          end else if (ev_lap) begin
            lap_reg   <= time_display;
            lap_count <= (lap_count == 4'd15) ? lap_count : lap_count + 4'd1;
            hold_cnt  <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_PAUSE: begin
          if (ev_start) begin
            start_pulse <= 1'b1;
            state       <= S_RUN;
          end else if (ev_clear) begin
            clear_pulse <= 1'b1;
            lap_count   <= 4'd0;
            lap_reg     <= 32'd0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign running       = (state == S_RUN) || (state == S_LAP);
  assign lap_active    = (state == S_LAP);
  assign display_value = lap_active ? lap_reg : time_display;

endmodule
